apb_master_bridge: RTL and testbench

- Upstream neighbour of the APB peripheral slaves (UART slave and siblings). Converts the SimpleRISC core's single-word load/store requests into APB transfers and decodes the target slave from the address.
- Drives one shared PADDR/PWRITE/PWDATA/PENABLE bus and a one-hot PSEL vector. Returns read data, completion and error to the core.
- Bounds every ACCESS phase with a timeout counter, because slave PREADY (e.g. UART TXIF) may stay low indefinitely.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_slave_decode.sv | 21 ++
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB constants and bridge state encoding
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int APB_TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_slave_decode.sv
// rtl/apb_slave_decode.sv - slave index to one-hot PSEL with a hit flag
module apb_slave_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  valid
);

  // Zero-extended compare so an index past NUM_SLAVES can never alias a low slave.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (32'(idx) == 32'(i));
    end
  end

  assign valid = |sel;

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core load/store to APB master with slave decode and access timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [APB_AW-1:0]     cpu_addr,
  input  logic [APB_DW-1:0]     cpu_wdata,
  output logic [APB_DW-1:0]     cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  cpu_busy,
  output logic [APB_AW-1:0]     PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DW-1:0]     PWDATA,
  input  logic [APB_DW-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [APB_AW-1:0]     paddr_q, paddr_d;
  logic [APB_DW-1:0]     pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [APB_DW-1:0]     rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_valid;

  apb_slave_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .IDX_W     (SEL_W)
  ) u_decode (
    .idx  (cpu_addr[SEL_LSB +: SEL_W]),
    .sel  (dec_sel),
    .valid(dec_valid)
  );

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !ack_q) begin
          paddr_d  = cpu_addr;
          pwrite_d = cpu_we;
          pwdata_d = cpu_wdata;
          rdata_d  = '0;
          if (dec_valid) begin
            psel_d  = dec_sel;
            busy_d  = 1'b1;
            state_d = ST_SETUP;
          end else begin
            // Decode miss: answer straight away without touching the bus.
            ack_d   = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          if (!pwrite_q) rdata_d = PRDATA;
          err_d     = PSLVERR;
          psel_d    = '0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            psel_d    = '0;
            penable_d = 1'b0;
            ack_d     = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_busy  = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_busy;
  logic [31:0] PADDR;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_total = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .NUM_SLAVES    (3),
    .SEL_LSB       (12),
    .SEL_W         (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_err  (cpu_err),
    .cpu_busy (cpu_busy),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always @(negedge PCLK) if (cpu_ack) ack_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request with req dropped after acceptance; waits<0 keeps PREADY low forever.
  // ack_cyc counts the IDLE acceptance cycle as cycle 1.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic err_in, input logic [31:0] rdata_in,
                      output int psel_cyc, output int pen_cyc, output int ack_cyc,
                      output logic [31:0] rdata, output logic err, output logic stable,
                      output logic busy_ok, output logic [2:0] psel_seen);
    psel_cyc = 0; pen_cyc = 0; ack_cyc = 0; rdata = 'x; err = 1'bx;
    stable = 1'b1; busy_ok = 1'b1; psel_seen = '0;
    @(negedge PCLK);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    PREADY = (waits == 0); PSLVERR = err_in; PRDATA = rdata_in;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge PCLK);
      if (cyc == 1) cpu_req = 1'b0;
      if (cpu_ack) begin
        ack_cyc = cyc + 1;
        rdata = cpu_rdata;
        err = cpu_err;
        if (cpu_busy !== 1'b0 || PSEL !== 3'b000 || PENABLE !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (cpu_busy !== 1'b1) busy_ok = 1'b0;
      if (PSEL !== 3'b000) begin
        psel_cyc++;
        psel_seen = psel_seen | PSEL;
        if (PADDR !== addr || PWRITE !== we || PWDATA !== wdata) stable = 1'b0;
      end
      if (PENABLE === 1'b1) begin
        pen_cyc++;
        if (waits >= 0 && pen_cyc > waits) PREADY = 1'b1;
      end
    end
    if (ack_cyc == 0) chk("xfer_ack_within_budget", 32'(0), 32'(1));
    PREADY = 1'b1; PSLVERR = 1'b0;
  endtask

  int          ps, pe, ac;
  logic [31:0] rd;
  logic        er, st, bo;
  logic [2:0]  sel;

  initial begin
    PRESETn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'(0));
    chk("rst_penable", 32'(PENABLE), 32'(0));
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'(0));
    chk("rst_ack_err_busy", 32'({cpu_ack, cpu_err, cpu_busy}), 32'(0));
    chk("rst_rdata", cpu_rdata, 32'h0);
    PRESETn = 1'b1;

    // 1: zero-wait write to slave 1
    xfer(1'b1, 32'h0000_1000, 32'h0000_00A5, 0, 1'b0, 32'hFFFF_FFFF, ps, pe, ac, rd, er, st, bo, sel);
    chk("t1_psel_cycles", 32'(ps), 32'(2));
    chk("t1_penable_cycles", 32'(pe), 32'(1));
    chk("t1_ack_cycle", 32'(ac), 32'(4));
    chk("t1_psel_onehot", 32'(sel), 32'(3'b010));
    chk("t1_err", 32'(er), 32'(0));
    chk("t1_write_rdata_zero", rd, 32'h0);
    chk("t1_bus_stable", 32'(st), 32'(1));
    chk("t1_busy", 32'(bo), 32'(1));

    // 2: read slave 0 with 3 wait states
    xfer(1'b0, 32'h0000_0000, 32'h0, 3, 1'b0, 32'h0000_0041, ps, pe, ac, rd, er, st, bo, sel);
    chk("t2_penable_cycles", 32'(pe), 32'(4));
    chk("t2_psel_cycles", 32'(ps), 32'(5));
    chk("t2_ack_cycle", 32'(ac), 32'(7));
    chk("t2_rdata", rd, 32'h0000_0041);
    chk("t2_err", 32'(er), 32'(0));
    chk("t2_psel_onehot", 32'(sel), 32'(3'b001));
    chk("t2_paddr_stable", 32'(st), 32'(1));
    chk("t2_busy", 32'(bo), 32'(1));

    // 3: write to slave 2, PREADY never rises, timeout after 8 ACCESS cycles
    xfer(1'b1, 32'h0000_2000, 32'h1234_5678, -1, 1'b0, 32'h0, ps, pe, ac, rd, er, st, bo, sel);
    chk("t3_penable_cycles", 32'(pe), 32'(8));
    chk("t3_psel_cycles", 32'(ps), 32'(9));
    chk("t3_ack_cycle", 32'(ac), 32'(11));
    chk("t3_err", 32'(er), 32'(1));
    chk("t3_rdata", rd, 32'h0);
    chk("t3_psel_onehot", 32'(sel), 32'(3'b100));

    // 4: slave error on read, then a clean read
    xfer(1'b0, 32'h0000_1004, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, ps, pe, ac, rd, er, st, bo, sel);
    chk("t4_ack_cycle", 32'(ac), 32'(4));
    chk("t4_err", 32'(er), 32'(1));
    chk("t4_rdata", rd, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h0000_0008, 32'h0, 0, 1'b0, 32'h1357_9BDF, ps, pe, ac, rd, er, st, bo, sel);
    chk("t4b_ack_cycle", 32'(ac), 32'(4));
    chk("t4b_err", 32'(er), 32'(0));
    chk("t4b_rdata", rd, 32'h1357_9BDF);

    // 5: decode miss, index 3 with 3 slaves
    xfer(1'b0, 32'h0000_3000, 32'h0, 0, 1'b0, 32'hAAAA_AAAA, ps, pe, ac, rd, er, st, bo, sel);
    chk("t5_psel_cycles", 32'(ps), 32'(0));
    chk("t5_ack_cycle", 32'(ac), 32'(2));
    chk("t5_err", 32'(er), 32'(1));
    chk("t5_rdata", rd, 32'h0);

    // 6: req held across two writes, reset during second ACCESS
    @(negedge PCLK);
    ack_total = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1010; cpu_wdata = 32'h11;
    PREADY = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("t6_first_ack", 32'(cpu_ack), 32'(1));
    cpu_addr = 32'h0000_2020; cpu_wdata = 32'h22; PREADY = 1'b0;
    @(negedge PCLK);
    chk("t6_idle_gap_psel", 32'(PSEL), 32'(0));
    @(negedge PCLK);
    chk("t6_second_setup_psel", 32'(PSEL), 32'(3'b100));
    chk("t6_second_pwdata", PWDATA, 32'h22);
    @(negedge PCLK);
    chk("t6_second_access_penable", 32'(PENABLE), 32'(1));
    #1 PRESETn = 1'b0;
    #1;
    chk("t6_async_psel", 32'(PSEL), 32'(0));
    chk("t6_async_penable", 32'(PENABLE), 32'(0));
    chk("t6_async_paddr", PADDR, 32'h0);
    chk("t6_async_pwdata", PWDATA, 32'h0);
    chk("t6_async_pwrite", 32'(PWRITE), 32'(0));
    chk("t6_async_busy", 32'(cpu_busy), 32'(0));
    @(negedge PCLK);
    cpu_req = 1'b0;
    PRESETn = 1'b1;
    PREADY = 1'b1;
    repeat (8) @(negedge PCLK);
    chk("t6_total_acks", 32'(ack_total), 32'(1));
    chk("t6_bus_idle_after", 32'({PSEL, PENABLE}), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
